ifetch_line_buffer: RTL and testbench

//  Instruction-side responder for the program counter's iaddr interface.

---
 rtl/ifetch_line_buffer.sv | 118 +++++++++++
 tb/tb_ifetch_line_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_line_buffer.sv
// One-line instruction buffer in front of instruction memory: serves hits combinationally,
// stalls the PC on a miss and refills the whole aligned line over a req/rdy handshake.
module ifetch_line_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iaddr,
    input  logic        hlt,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        instr_vld,
    output logic        fetch_stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rdata
);

    localparam int TAG_W = 16 - OFF_W;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic               line_vld_q, line_vld_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               discard_q, discard_d;
    logic               mem_req_q, mem_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        data_q [LINE_WORDS];

    logic               hit;
    logic               data_we;

    assign hit         = line_vld_q && (tag_q == iaddr[15:OFF_W]);
    assign instr       = hit ? data_q[iaddr[OFF_W-1:0]] : 16'h0000;
    assign instr_vld   = hit;
    assign fetch_stall = !hit;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Words are only accepted while a request is actually outstanding.
    assign data_we = (state_q == FILL) && mem_rdy;

    always_comb begin
        state_d    = state_q;
        line_vld_d = line_vld_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        discard_d  = discard_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (flush) begin
                    line_vld_d = 1'b0;
                end else if (!hit && !hlt) begin
                    state_d    = FILL;
                    line_vld_d = 1'b0;
                    tag_d      = iaddr[15:OFF_W];
                    cnt_d      = '0;
                    discard_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {iaddr[15:OFF_W], {OFF_W{1'b0}}};
                end
            end
            FILL: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (mem_rdy) begin
                    cnt_d      = cnt_q + 1'b1;
                    mem_addr_d = mem_addr_q + 16'd1;
                    if (cnt_q == LAST_CNT) begin
                        // A flush anywhere in the fill, including this last beat, drops the line.
                        state_d    = IDLE;
                        mem_req_d  = 1'b0;
                        line_vld_d = !(discard_q || flush);
                        discard_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            line_vld_q <= 1'b0;
            tag_q      <= '0;
            cnt_q      <= '0;
            discard_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            line_vld_q <= line_vld_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            discard_q  <= discard_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Line storage carries no reset; line_vld_q guards every read.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[cnt_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed bench for ifetch_line_buffer: per-cycle vector table plus a hand-written
// mid-fill reset and top-of-memory refill sequence.
module tb_ifetch_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] iaddr;
    logic        hlt;
    logic        flush;
    logic [15:0] instr;
    logic        instr_vld;
    logic        fetch_stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Backing memory image: each word holds 16'hA000 plus its own address.
    assign mem_rdata = 16'hA000 + mem_addr;

    ifetch_line_buffer #(.LINE_WORDS(4), .OFF_W(2)) dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .hlt(hlt), .flush(flush),
        .instr(instr), .instr_vld(instr_vld), .fetch_stall(fetch_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [15:0] iaddr;
        logic        hlt;
        logic        flush;
        logic        rdy;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_vld;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] a, input logic h, input logic f, input logic r,
                       input logic req, input logic [15:0] ma, input logic v, input logic [15:0] ins);
        vec_t e;
        e.iaddr = a; e.hlt = h; e.flush = f; e.rdy = r;
        e.exp_req = req; e.exp_addr = ma; e.exp_vld = v; e.exp_instr = ins;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int k;
        int budget;
        rst = 1'b1; iaddr = 16'h0000; hlt = 1'b1; flush = 1'b0; mem_rdy = 1'b1;

        // T1: cold fill of line 0 with mem_rdy high
        add(16'h0000,0,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0000,0,0,1, 1,16'h0000,0,16'h0000);
        add(16'h0000,0,0,1, 1,16'h0001,0,16'h0000);
        add(16'h0000,0,0,1, 1,16'h0002,0,16'h0000);
        add(16'h0000,0,0,1, 1,16'h0003,0,16'h0000);
        add(16'h0000,0,0,1, 0,16'h0000,1,16'hA000);
        // T2: sequential hits, then a miss on the next line
        add(16'h0001,0,0,1, 0,16'h0000,1,16'hA001);
        add(16'h0002,0,0,1, 0,16'h0000,1,16'hA002);
        add(16'h0003,0,0,1, 0,16'h0000,1,16'hA003);
        add(16'h0004,0,0,1, 0,16'h0000,0,16'h0000);
        for (int i = 0; i < 4; i++) add(16'h0004,0,0,1, 1,16'(16'h0004+i),0,16'h0000);
        add(16'h0004,0,0,1, 0,16'h0000,1,16'hA004);
        // T3: mem_rdy 1-0-0-1 then high
        add(16'h0008,0,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0008,0,0,1, 1,16'h0008,0,16'h0000);
        add(16'h0008,0,0,0, 1,16'h0009,0,16'h0000);
        add(16'h0008,0,0,0, 1,16'h0009,0,16'h0000);
        add(16'h0008,0,0,1, 1,16'h0009,0,16'h0000);
        add(16'h0008,0,0,1, 1,16'h000A,0,16'h0000);
        add(16'h0008,0,0,1, 1,16'h000B,0,16'h0000);
        add(16'h0008,0,0,1, 0,16'h0000,1,16'hA008);
        add(16'h0009,0,0,1, 0,16'h0000,1,16'hA009);
        add(16'h000B,0,0,1, 0,16'h0000,1,16'hA00B);
        // T4: flush in the 2nd fill cycle forces a refetch
        add(16'h0010,0,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0010,0,0,1, 1,16'h0010,0,16'h0000);
        add(16'h0010,0,1,1, 1,16'h0011,0,16'h0000);
        add(16'h0010,0,0,1, 1,16'h0012,0,16'h0000);
        add(16'h0010,0,0,1, 1,16'h0013,0,16'h0000);
        add(16'h0010,0,0,1, 0,16'h0000,0,16'h0000);
        for (int i = 0; i < 4; i++) add(16'h0010,0,0,1, 1,16'(16'h0010+i),0,16'h0000);
        add(16'h0010,0,0,1, 0,16'h0000,1,16'hA010);
        add(16'h0013,0,0,1, 0,16'h0000,1,16'hA013);
        // T5: hlt blocks the fill; hlt+flush on a hit invalidates without fetching
        add(16'h0020,1,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0020,1,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0020,1,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0020,0,0,1, 0,16'h0000,0,16'h0000);
        for (int i = 0; i < 4; i++) add(16'h0020,0,0,1, 1,16'(16'h0020+i),0,16'h0000);
        add(16'h0020,0,0,1, 0,16'h0000,1,16'hA020);
        add(16'h0020,1,1,1, 0,16'h0000,1,16'hA020);
        add(16'h0020,1,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0020,1,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0020,0,0,1, 0,16'h0000,0,16'h0000);
        for (int i = 0; i < 4; i++) add(16'h0020,0,0,1, 1,16'(16'h0020+i),0,16'h0000);
        add(16'h0020,0,0,1, 0,16'h0000,1,16'hA020);
        // flush coinciding with the final accepted word
        add(16'h0040,0,0,1, 0,16'h0000,0,16'h0000);
        add(16'h0040,0,0,1, 1,16'h0040,0,16'h0000);
        add(16'h0040,0,0,1, 1,16'h0041,0,16'h0000);
        add(16'h0040,0,0,1, 1,16'h0042,0,16'h0000);
        add(16'h0040,0,1,1, 1,16'h0043,0,16'h0000);
        add(16'h0040,0,0,1, 0,16'h0000,0,16'h0000);
        for (int i = 0; i < 4; i++) add(16'h0040,0,0,1, 1,16'(16'h0040+i),0,16'h0000);
        add(16'h0042,0,0,1, 0,16'h0000,1,16'hA042);

        // Reset state
        #3;
        check("rst_mem_req", 16'(mem_req), 16'h0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_instr_vld", 16'(instr_vld), 16'h0);
        check("rst_instr", instr, 16'h0000);
        check("rst_stall", 16'(fetch_stall), 16'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            iaddr = vecs[i].iaddr; hlt = vecs[i].hlt; flush = vecs[i].flush; mem_rdy = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d_req", i), 16'(mem_req), 16'(vecs[i].exp_req));
            if (vecs[i].exp_req) check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_vld", i), 16'(instr_vld), 16'(vecs[i].exp_vld));
            check($sformatf("v%0d_stall", i), 16'(fetch_stall), 16'(!vecs[i].exp_vld));
            check($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
            $display("vec %0d: iaddr=%h req=%b addr=%h vld=%b instr=%h", i, iaddr, mem_req, mem_addr, instr_vld, instr);
        end

        // T6: reset mid-fill drops mem_req asynchronously, then fill the top line
        @(posedge clk); #1;
        iaddr = 16'h0030; hlt = 1'b0; flush = 1'b0; mem_rdy = 1'b1;
        budget = 0;
        while (!mem_req && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("t6_fill_started", 16'(mem_req), 16'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_req", 16'(mem_req), 16'h0);
        check("t6_async_addr", mem_addr, 16'h0000);
        check("t6_async_stall", 16'(fetch_stall), 16'h1);
        iaddr = 16'hFFFE; hlt = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        hlt = 1'b0;
        k = 0;
        budget = 0;
        while (budget < 20) begin
            @(negedge clk);
            budget++;
            if (instr_vld) break;
            if (mem_req) begin
                check($sformatf("t6_addr%0d", k), mem_addr, 16'(16'hFFFC + k));
                k++;
            end
        end
        check("t6_timeout", 16'(instr_vld), 16'h1);
        check("t6_words", 16'(k), 16'd4);
        check("t6_instr_fffe", instr, 16'h9FFE);
        $display("t6: iaddr=%h vld=%b instr=%h words=%0d", iaddr, instr_vld, instr, k);
        @(posedge clk); #1;
        iaddr = 16'hFFFF; hlt = 1'b1;
        @(negedge clk);
        check("t6_instr_ffff", instr, 16'h9FFF);
        @(posedge clk); #1;
        iaddr = 16'hFFFC;
        @(negedge clk);
        check("t6_instr_fffc", instr, 16'h9FFC);
        @(posedge clk); #1;
        iaddr = 16'h0000;
        @(negedge clk);
        check("t6_no_wrap_vld", 16'(instr_vld), 16'h0);
        check("t6_no_wrap_req", 16'(mem_req), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
